com_bus_arbiter_param: RTL and testbench

COM_BUS_ARBITER_PARAM -- requirements
Module: com_bus_arbiter_param

---
 rtl/com_bus_arbiter_param.sv | 214 +++++++++++++++++++++
 tb/tb_com_bus_arbiter_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/com_bus_arbiter_param.sv
// ---------------------------------------------------------------------------
// com_bus_arbiter_param
//   Common-bus arbiter. Processor-side requesters win the bus round-robin;
//   while a processor owns the bus, snoop-side requesters (cache snoop ports,
//   then the memory snoop port) are served one at a time by fixed priority,
//   nested inside the processor grant. All grants are registered.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   -> a processor tenure is capped at TIMEOUT_CYC cycles. The bus
//                is then revoked, Arb_timeout pulses, and the arbiter waits
//                for the revoked owner to drop its request before it
//                arbitrates again.
//   Undefined -> no counter and no WAIT_DROP state. Arb_timeout is tied low.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   Com_Bus_Req_proc   [N_PROC]  level requests, processor side
//   Com_Bus_Req_snoop  [N_SNOOP] level requests, cache snoop side
//   Mem_snoop_req      memory snoop request (lowest snoop priority)
//   Com_Bus_Gnt_proc   [N_PROC]  one-hot processor grant
//   Com_Bus_Gnt_snoop  [N_SNOOP] one-hot snoop grant
//   Mem_snoop_gnt      memory snoop grant
//   Bus_owner          index of the processor grantee, 0 when there is none
//   Bus_busy           high while any grant is high
//   Arb_timeout        one-cycle pulse when a grant is forcibly revoked
// ---------------------------------------------------------------------------
module com_bus_arbiter_param #(
  parameter int N_PROC      = 8,
  parameter int N_SNOOP     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PROC-1:0]         Com_Bus_Req_proc,
  input  logic [N_SNOOP-1:0]        Com_Bus_Req_snoop,
  input  logic                      Mem_snoop_req,
  output logic [N_PROC-1:0]         Com_Bus_Gnt_proc,
  output logic [N_SNOOP-1:0]        Com_Bus_Gnt_snoop,
  output logic                      Mem_snoop_gnt,
  output logic [$clog2(N_PROC)-1:0] Bus_owner,
  output logic                      Bus_busy,
  output logic                      Arb_timeout
);

  localparam int OW = $clog2(N_PROC);
  localparam int SW = N_SNOOP + 1;   // snoop ports plus the memory port at the top
  localparam logic [OW:0]       NP_W     = (OW+1)'(N_PROC);
  localparam logic [N_PROC-1:0] PROC_ONE = N_PROC'(1);

  if (N_PROC < 2 || N_SNOOP < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("com_bus_arbiter_param: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    PROC,
    SNOOP,
    RELEASE
`ifdef ARB_TIMEOUT_EN
    , WAIT_DROP
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [N_PROC-1:0] gnt_proc_q, gnt_proc_d;
  logic [SW-1:0]     gnt_snp_q, gnt_snp_d;
  logic [OW-1:0]     bus_owner_q, bus_owner_d;
  logic              busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] owner_q, owner_d;   // survives revocation so WAIT_DROP knows whom to watch
  logic          tmo_q, tmo_d;
`endif

  // ---------------- round-robin pick ----------------
  // Rotate the request vector so the pointer sits at bit 0, find the lowest
  // set bit, and rotate the offset back into an absolute index.
  logic [N_PROC-1:0] rot;
  logic [OW-1:0]     rr_ofs, rr_win, ptr_nxt;
  logic [OW:0]       rr_sum, nxt_sum;

  always_comb begin
    rot    = N_PROC'({Com_Bus_Req_proc, Com_Bus_Req_proc} >> ptr_q);
    rr_ofs = '0;
    for (int i = N_PROC-1; i >= 0; i--) begin
      if (rot[i]) rr_ofs = OW'(i);
    end
    rr_sum = {1'b0, ptr_q} + {1'b0, rr_ofs};
    if (rr_sum >= NP_W) rr_sum = rr_sum - NP_W;
    rr_win  = rr_sum[OW-1:0];
    nxt_sum = {1'b0, rr_win} + (OW+1)'(1);
    ptr_nxt = (nxt_sum == NP_W) ? '0 : nxt_sum[OW-1:0];
  end

  // ---------------- snoop fixed priority ----------------
  // x & -x isolates the lowest set bit: lowest snoop index first, memory last.
  logic [SW-1:0] snp_req, snp_pick;
  assign snp_req  = {Mem_snoop_req, Com_Bus_Req_snoop};
  assign snp_pick = snp_req & (-snp_req);

  // ---------------- next state ----------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snp_d   = gnt_snp_q;
    bus_owner_d = bus_owner_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    owner_d = owner_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|Com_Bus_Req_proc) begin
          gnt_proc_d  = PROC_ONE << rr_win;
          bus_owner_d = rr_win;
          ptr_d       = ptr_nxt;
          state_d     = PROC;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
          owner_d = rr_win;
`endif
        end
      end
      PROC, SNOOP: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == TC_LAST) begin
          gnt_proc_d  = '0;
          gnt_snp_d   = '0;
          bus_owner_d = '0;
          tmo_d       = 1'b1;
          state_d     = WAIT_DROP;
        end else
`endif
        if (state_q == PROC) begin
          // Snoops take precedence over the owner's release: the proc grant
          // is kept until the snoop tenure ends.
          if (|snp_req) begin
            gnt_snp_d = snp_pick;
            state_d   = SNOOP;
          end else if (~|(gnt_proc_q & Com_Bus_Req_proc)) begin
            gnt_proc_d  = '0;
            bus_owner_d = '0;
            state_d     = RELEASE;
          end
        end else if (~|(gnt_snp_q & snp_req)) begin
          // Back to PROC for one cycle; remaining snoops re-arbitrate there.
          gnt_snp_d = '0;
          state_d   = PROC;
        end
      end
      RELEASE: state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
      WAIT_DROP: begin
        if (!Com_Bus_Req_proc[owner_q]) state_d = IDLE;
      end
`endif
      default: begin
        gnt_proc_d  = '0;
        gnt_snp_d   = '0;
        bus_owner_d = '0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (|gnt_proc_d) | (|gnt_snp_d);
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_proc_q  <= '0;
      gnt_snp_q   <= '0;
      bus_owner_q <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      owner_q     <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snp_q   <= gnt_snp_d;
      bus_owner_q <= bus_owner_d;
      busy_q      <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign Com_Bus_Gnt_proc  = gnt_proc_q;
  assign Com_Bus_Gnt_snoop = gnt_snp_q[N_SNOOP-1:0];
  assign Mem_snoop_gnt     = gnt_snp_q[N_SNOOP];
  assign Bus_owner         = bus_owner_q;
  assign Bus_busy          = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign Arb_timeout       = tmo_q;
`else
  assign Arb_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_com_bus_arbiter_param.sv
// ---------------------------------------------------------------------------
// tb_com_bus_arbiter_param
//   Directed scenarios plus randomized traffic against a behavioural model of
//   the arbiter's bus ownership (who holds the bus, who is snooping, whether
//   the bus is in its release gap or waiting out a revoked owner).
//   Honours ARB_TIMEOUT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_com_bus_arbiter_param;
  localparam int NP = 8;
  localparam int NS = 4;
  localparam int TC = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_proc;
  logic [NS-1:0] req_snp;
  logic          mem_req;
  logic [NP-1:0] gnt_proc;
  logic [NS-1:0] gnt_snp;
  logic          mem_gnt;
  logic [2:0]    owner;
  logic          busy, tmo;

  int checks   = 0;
  int failures = 0;

  com_bus_arbiter_param #(.N_PROC(NP), .N_SNOOP(NS), .TIMEOUT_CYC(TC)) dut (
    .clk               (clk),
    .rst               (rst),
    .Com_Bus_Req_proc  (req_proc),
    .Com_Bus_Req_snoop (req_snp),
    .Mem_snoop_req     (mem_req),
    .Com_Bus_Gnt_proc  (gnt_proc),
    .Com_Bus_Gnt_snoop (gnt_snp),
    .Mem_snoop_gnt     (mem_gnt),
    .Bus_owner         (owner),
    .Bus_busy          (busy),
    .Arb_timeout       (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_proc;   // bus owner, -1 none
  int m_snp;    // snoop owner (NS = memory), -1 none
  int m_wait;   // revoked owner still requesting, -1 none
  int m_ptr;    // first index searched by the next round-robin pick
  int m_cnt;    // cycles of the current tenure
  bit m_rel;    // one-cycle release gap
  bit m_tmo;

  function automatic bit snp_req_of(int k);
    return (k == NS) ? mem_req : req_snp[k];
  endfunction

  task automatic m_reset();
    m_proc = -1; m_snp = -1; m_wait = -1; m_ptr = 0; m_cnt = 0; m_rel = 0; m_tmo = 0;
  endtask

  task automatic m_step();
    m_tmo = 0;
    if (m_rel) m_rel = 0;
    else if (m_wait >= 0) begin
      if (!req_proc[m_wait]) m_wait = -1;
    end else if (m_proc < 0) begin
      for (int i = 0; i < NP; i++) begin
        int k;
        k = (m_ptr + i) % NP;
        if (req_proc[k]) begin
          m_proc = k; m_ptr = (k + 1) % NP; m_cnt = 0;
          break;
        end
      end
    end else begin
      m_cnt++;
      if (TMO_EN && m_cnt == TC) begin
        m_wait = m_proc; m_proc = -1; m_snp = -1; m_tmo = 1;
      end else if (m_snp >= 0) begin
        if (!snp_req_of(m_snp)) m_snp = -1;
      end else if (req_snp != 0 || mem_req) begin
        for (int k = 0; k <= NS; k++) begin
          if (snp_req_of(k)) begin m_snp = k; break; end
        end
      end else if (!req_proc[m_proc]) begin
        m_proc = -1; m_rel = 1;
      end
    end
  endtask

  task automatic check_outs();
    logic [NP-1:0] eg;
    logic [NS:0]   es;
    eg = (m_proc >= 0) ? (NP'(1) << m_proc) : '0;
    es = (m_snp  >= 0) ? ((NS+1)'(1) << m_snp) : '0;
    chk("gnt_proc",  32'(gnt_proc), 32'(eg));
    chk("gnt_snoop", 32'({mem_gnt, gnt_snp}), 32'(es));
    chk("bus_owner", 32'(owner), (m_proc >= 0) ? 32'(m_proc) : 32'd0);
    chk("bus_busy",  32'(busy), 32'(eg != 0 || es != 0));
    chk("timeout",   32'(tmo), 32'(m_tmo));
  endtask

  // one clock: model advances on the same edge as the DUT, outputs read 1ns later
  task automatic step();
    @(posedge clk);
    if (rst) m_reset(); else m_step();
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_proc = '0; req_snp = '0; mem_req = 1'b0;
    m_reset();
    #1;
    check_outs();
    step();
    rst = 1'b0;
  endtask

  logic [NP-1:0] hold_mask, prev_g;
  logic [NP-1:0] seen[$];
  int            n, tmo_at;
  bit            tmo_seen;

  initial begin
    rst = 1'b0; req_proc = '0; req_snp = '0; mem_req = 1'b0;
    m_reset();
    // reset takes effect with no clock edge
    #1 rst = 1'b1;
    #1;
    check_outs();
    step();
    rst = 1'b0;

    // single requester: grant after one cycle, drop after release
    req_proc = 8'h01; step();
    chk("single_gnt", 32'(gnt_proc), 32'h01);
    chk("single_owner", 32'(owner), 32'd0);
    repeat (4) step();
    req_proc = 8'h00; step();
    chk("single_drop", 32'(gnt_proc), 32'h00);
    step();
    chk("single_busy", 32'(busy), 32'd0);

    // two requesters alternate under round-robin
    do_reset();
    hold_mask = '1; prev_g = '0; seen.delete();
    for (int c = 0; c < 14; c++) begin
      req_proc = 8'h05 & hold_mask;
      step();
      if (gnt_proc != 0 && gnt_proc != prev_g) seen.push_back(gnt_proc);
      prev_g = gnt_proc;
      hold_mask = (m_proc >= 0) ? ~(NP'(1) << m_proc) : '1;
    end
    chk("rr_count", 32'(seen.size() >= 3), 32'd1);
    if (seen.size() >= 3) begin
      chk("rr_first",  32'(seen[0]), 32'h01);
      chk("rr_second", 32'(seen[1]), 32'h04);
      chk("rr_third",  32'(seen[2]), 32'h01);
    end

    // nested snoops in priority order, memory last, proc grant held
    do_reset();
    req_proc = 8'h02; step();
    chk("snp_proc", 32'(gnt_proc), 32'h02);
    req_snp = 4'h6; mem_req = 1'b1; step();
    chk("snp_first", 32'(gnt_snp), 32'h2);
    req_snp = 4'h4; step(); step();
    chk("snp_second", 32'(gnt_snp), 32'h4);
    req_snp = 4'h0; step(); step();
    chk("snp_mem", 32'(mem_gnt), 32'd1);
    chk("snp_proc_held", 32'(gnt_proc), 32'h02);

    // reset asserted during a snoop tenure clears grants immediately
    #2 rst = 1'b1;
    #1;
    chk("rst_async", 32'({gnt_proc, gnt_snp, mem_gnt, busy, owner}), 32'd0);
    m_reset();
    check_outs();
    req_proc = '0; req_snp = '0; mem_req = 1'b0;
    step();
    rst = 1'b0;
    req_proc = 8'h80; step();
    chk("rst_regrant", 32'(gnt_proc), 32'h80);

    // memory snoop never granted without a proc owner
    do_reset();
    mem_req = 1'b1;
    repeat (3) begin
      step();
      chk("mem_no_owner", 32'(mem_gnt), 32'd0);
    end
    req_proc = 8'h10; step();
    chk("mem_owner", 32'(gnt_proc), 32'h10);
    step();
    chk("mem_gnt", 32'(mem_gnt), 32'd1);
    mem_req = 1'b0; req_proc = '0;
    repeat (4) step();

    // long tenure: revoked after TC cycles only when the timeout is built in
    do_reset();
    req_proc = 8'h08; step();
    n = 0; tmo_seen = 0; tmo_at = 0;
    repeat (TC + 4) begin
      step();
      n++;
      if (tmo && !tmo_seen) begin tmo_seen = 1; tmo_at = n; end
    end
`ifdef ARB_TIMEOUT_EN
    chk("tmo_seen", 32'(tmo_seen), 32'd1);
    chk("tmo_at", 32'(tmo_at), 32'(TC));
    chk("tmo_no_regrant", 32'(gnt_proc), 32'h00);
    req_proc = '0; step();
    req_proc = 8'h08; step();
    chk("tmo_regrant", 32'(gnt_proc), 32'h08);
`else
    chk("tmo_absent", 32'(tmo_seen), 32'd0);
    chk("tmo_held", 32'(gnt_proc), 32'h08);
`endif
    req_proc = '0;
    repeat (3) step();

    // randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) if ($urandom_range(7) == 0) req_proc[i] = ~req_proc[i];
      for (int i = 0; i < NS; i++) if ($urandom_range(3) == 0) req_snp[i] = ~req_snp[i];
      if ($urandom_range(5) == 0) mem_req = ~mem_req;
      if ($urandom_range(499) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
